// File: rtl/fetch_stage_pkg.sv
// Shared LC-3b types for the fetch stage: machine word, fetch FSM states, NOP encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    SQUASH
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_NOP = 16'h0000;

  // Sequential PC step; 16-bit so FFFE wraps to 0000.
  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory read handshake between the fetch stage (master) and memory (slave).
interface fetch_stage_if;

  logic                 imem_read;
  lc3b_types::lc3b_word imem_address;
  logic                 imem_resp;
  lc3b_types::lc3b_word imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds its contents.
module if_id_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     flush,
  input  lc3b_word load_instr,
  input  lc3b_word load_pc,
  output lc3b_word instruction,
  output lc3b_word pc_out,
  output lc3b_word pc_plus2_out,
  output logic     valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instruction  <= LC3B_NOP;
      pc_out       <= '0;
      pc_plus2_out <= '0;
      valid        <= 1'b0;
    end else if (load) begin
      instruction  <= load_instr;
      pc_out       <= load_pc;
      pc_plus2_out <= pc_inc(load_pc);
      valid        <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: PC, imem read FSM (FETCH/HOLD/SQUASH), hold buffer, IF/ID register.
// Optional FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hazard_stall,
  input  logic                 redirect_en,
  input  lc3b_word             redirect_pc,
  fetch_stage_if.master        imem,
  output lc3b_word             instruction,
  output lc3b_word             pc_out,
  output lc3b_word             pc_plus2_out,
  output logic                 valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_count,
  output logic [31:0]          perf_stall_cycles
`endif
);

  lc3b_fetch_state state;
  lc3b_word        pc;
  lc3b_word        hold_word;
  lc3b_word        hold_pc;
  lc3b_word        squash_addr;

  logic            load;
  logic            flush;
  lc3b_word        load_instr;
  lc3b_word        load_pc;

  // SQUASH keeps presenting the abandoned address until its response drains.
  assign imem.imem_read    = (state != HOLD);
  assign imem.imem_address = (state == SQUASH) ? squash_addr : pc;

  always_comb begin
    load       = 1'b0;
    flush      = 1'b0;
    load_instr = imem.imem_rdata;
    load_pc    = pc;
    if (redirect_en) begin
      flush = 1'b1;
    end else begin
      case (state)
        FETCH:   load = imem.imem_resp && !hazard_stall;
        HOLD: begin
          load       = !hazard_stall;
          load_instr = hold_word;
          load_pc    = hold_pc;
        end
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hold_word   <= LC3B_NOP;
      hold_pc     <= '0;
      squash_addr <= '0;
    end else if (redirect_en) begin
      pc        <= redirect_pc;
      hold_word <= LC3B_NOP;
      case (state)
        FETCH: begin
          if (!imem.imem_resp) begin
            squash_addr <= pc;
            state       <= SQUASH;
          end
        end
        HOLD:    state <= FETCH;
        default: state <= state;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_resp) begin
            pc <= pc_inc(pc);
            if (hazard_stall) begin
              hold_word <= imem.imem_rdata;
              hold_pc   <= pc;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!hazard_stall) state <= FETCH;
        end
        SQUASH: begin
          if (imem.imem_resp) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .flush        (flush),
    .load_instr   (load_instr),
    .load_pc      (load_pc),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .pc_plus2_out (pc_plus2_out),
    .valid        (valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_count  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (load && !flush)
        perf_fetch_count <= perf_fetch_count + 32'd1;
      if (state == HOLD || (state == FETCH && !imem.imem_resp))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
